fp_adder_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 add/subtract unit; generic successor of the combinational FP32 adder.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_lzc.sv | 28 ++
 rtl/fp_adder_pipe.sv | 255 +++++++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and format helpers for the pipelined IEEE-754 adder.
// Rounding-mode encodings, flag bit positions and width-generic NaN/max-finite patterns.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    function automatic int unsigned fp_width(int unsigned exp_w, int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // {1, all-ones exponent, 1, zeros}: a run of exp_w+2 ones ending at bit man_w-1
    function automatic logic [63:0] fp_qnan(int unsigned exp_w, int unsigned man_w);
        return ((64'd1 << (exp_w + 2)) - 64'd1) << (man_w - 1);
    endfunction

    // Magnitude only (sign excluded): exponent all-ones minus one, fraction all ones
    function automatic logic [63:0] fp_max_finite(int unsigned exp_w, int unsigned man_w);
        return ((64'd1 << (exp_w + man_w)) - 64'd1) - (64'd1 << man_w);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter built as a log-depth OR/shift tree.
// An all-zero input returns WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]             data_i,
    output logic [$clog2(WIDTH+1)-1:0]   cnt_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned PadW = 1 << CntW;

    logic [PadW-1:0] pad;

    // A marker one after the data bounds the count at WIDTH for a zero input
    always_comb begin
        pad                     = '0;
        pad[PadW-1 -: WIDTH+1]  = {data_i, 1'b1};
        cnt_o                   = '0;
        for (int i = CntW - 1; i >= 0; i--) begin
            if ((pad >> (PadW - (1 << i))) == '0) begin
                cnt_o[i] = 1'b1;
                pad      = pad << (1 << i);
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage elastic IEEE-754 add/subtract: align, add+normalise, round+pack.
// Define FP_ADDER_FLAGS_EN to add the {invalid, overflow, underflow, inexact} Flags port.
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [EXP_W+MAN_W:0]     Data_A,
    input  logic [EXP_W+MAN_W:0]     Data_B,
    input  logic                     Mode,
    input  logic [1:0]               RMode,
    input  logic                     Valid_In,
    output logic                     Ready_In,
    output logic [EXP_W+MAN_W:0]     Data_Out,
    output logic                     Valid_Out,
`ifdef FP_ADDER_FLAGS_EN
    output logic [3:0]               Flags,
`endif
    input  logic                     Ready_Out
);

    localparam int unsigned W    = fp_width(EXP_W, MAN_W);
    localparam int unsigned MW   = MAN_W + 4;
    localparam int unsigned XW   = EXP_W + 2;
    localparam int unsigned SHW  = $clog2(MW + 1);
    localparam int unsigned MagW = W - 1;

    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [MagW-1:0]  MAX_MAG  = MagW'(fp_max_finite(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // ---------------- elastic control ----------------
    logic v1_q, v2_q, v3_q, rdy_q;
    logic en1, en2, en3, accept;

    assign en3      = ~v3_q | Ready_Out;
    assign en2      = ~v2_q | en3;
    assign en1      = ~v1_q | en2;
    assign Ready_In = rdy_q & en1;
    assign accept   = Valid_In & Ready_In;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdy_q <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (en1) v1_q <= accept;
            if (en2) v2_q <= v1_q;
            if (en3) v3_q <= v2_q;
        end
    end

    // ---------------- stage 1: classify, swap, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, diff;
    logic [MAN_W-1:0] fa, fb, fl, fs;
    logic             swap, eff_sub, sl;
    logic             nan_a, nan_b, inf_a, inf_b, is_nan, is_inf;
    logic [SHW-1:0]   shamt;
    logic [2*MW-1:0]  wide;
    logic [MW-1:0]    s1_ms_d;

    assign {sa, ea, fa} = Data_A;
    assign sb           = Data_B[W-1] ^ Mode;
    assign eb           = Data_B[W-2 -: EXP_W];
    assign fb           = Data_B[MAN_W-1:0];
    assign eff_sub      = sa ^ sb;

    assign nan_a  = (&ea) & (|fa);
    assign nan_b  = (&eb) & (|fb);
    assign inf_a  = (&ea) & ~(|fa);
    assign inf_b  = (&eb) & ~(|fb);
    assign is_nan = nan_a | nan_b | (inf_a & inf_b & eff_sub);
    assign is_inf = (inf_a | inf_b) & ~is_nan;

    always_comb begin
        swap   = {eb, fb} > {ea, fa};
        el     = swap ? eb : ea;
        es     = swap ? ea : eb;
        fl     = swap ? fb : fa;
        fs     = swap ? fa : fb;
        sl     = swap ? sb : sa;
        // Subnormals behave as exponent 1, giving the diff-1 shift against a normal operand
        el_eff = (el == '0) ? EXP_W'(1) : el;
        es_eff = (es == '0) ? EXP_W'(1) : es;
        diff   = el_eff - es_eff;
        shamt  = (32'(diff) > MW - 1) ? SHW'(MW - 1) : SHW'(diff);
        wide   = {{(|es), fs, 3'b000}, {MW{1'b0}}} >> shamt;
        s1_ms_d = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
    end

    logic             s1_sign_q, s1_sub_q, s1_spec_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MW-1:0]    s1_ml_q, s1_ms_q;
    logic [1:0]       s1_rm_q;
    logic [W-1:0]     s1_spec_val_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_ml_q       <= '0;
            s1_ms_q       <= '0;
            s1_rm_q       <= '0;
            s1_spec_val_q <= '0;
        end else if (accept) begin
            s1_sign_q     <= sl;
            s1_sub_q      <= eff_sub;
            s1_spec_q     <= is_nan | is_inf;
            s1_exp_q      <= el_eff;
            s1_ml_q       <= {(|el), fl, 3'b000};
            s1_ms_q       <= s1_ms_d;
            s1_rm_q       <= RMode;
            s1_spec_val_q <= is_nan ? QNAN : {sl, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // ---------------- stage 2: add/sub, normalise ----------------
    logic [MW:0]    sum;
    logic [SHW-1:0] lz;
    int unsigned    sh;
    logic           s2_sign_d;
    logic [XW-1:0]  s2_exp_d;
    logic [MW-1:0]  s2_mant_d;

    fp_lzc #(.WIDTH(MW)) u_lzc (
        .data_i (sum[MW-1:0]),
        .cnt_o  (lz)
    );

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                       : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
        sh  = 0;
        if (sum[MW]) begin
            s2_mant_d = {sum[MW:2], sum[1] | sum[0]};
            s2_exp_d  = XW'(s1_exp_q) + XW'(1);
        end else begin
            // Never normalise below exponent 1; what remains is a subnormal
            sh        = (32'(lz) < 32'(s1_exp_q) - 1) ? 32'(lz) : 32'(s1_exp_q) - 1;
            s2_mant_d = sum[MW-1:0] << sh;
            s2_exp_d  = XW'(32'(s1_exp_q) - sh);
        end
        s2_sign_d = s1_sign_q;
        if (sum == '0 && s1_sub_q) s2_sign_d = (s1_rm_q == RM_RDN);
    end

    logic           s2_sign_q, s2_spec_q;
    logic [XW-1:0]  s2_exp_q;
    logic [MW-1:0]  s2_mant_q;
    logic [1:0]     s2_rm_q;
    logic [W-1:0]   s2_spec_val_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s2_sign_q     <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_mant_q     <= '0;
            s2_rm_q       <= '0;
            s2_spec_val_q <= '0;
        end else if (en2 && v1_q) begin
            s2_sign_q     <= s2_sign_d;
            s2_spec_q     <= s1_spec_q;
            s2_exp_q      <= s2_exp_d;
            s2_mant_q     <= s2_mant_d;
            s2_rm_q       <= s1_rm_q;
            s2_spec_val_q <= s1_spec_val_q;
        end
    end

    // ---------------- stage 3: round, overflow, pack ----------------
    logic [MAN_W:0]   rnd_man;
    logic             g_bit, r_bit, s_bit, inexact_r, inc, to_inf, ovf, hidden;
    logic [MAN_W+1:0] mr;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     out_d, out_q;

    always_comb begin
        {rnd_man, g_bit, r_bit, s_bit} = s2_mant_q;
        inexact_r = g_bit | r_bit | s_bit;
        case (s2_rm_q)
            RM_RNE:  inc = g_bit & (r_bit | s_bit | rnd_man[0]);
            RM_RDN:  inc = inexact_r & s2_sign_q;
            RM_RUP:  inc = inexact_r & ~s2_sign_q;
            default: inc = 1'b0;
        endcase
        mr     = {1'b0, rnd_man} + {{(MAN_W+1){1'b0}}, inc};
        exp_r  = s2_exp_q + {{(XW-1){1'b0}}, mr[MAN_W+1]};
        hidden = |mr[MAN_W+1:MAN_W];
        ovf    = exp_r >= {2'b00, EXP_ONES};
        to_inf = (s2_rm_q == RM_RNE) | ((s2_rm_q == RM_RDN) & s2_sign_q)
               | ((s2_rm_q == RM_RUP) & ~s2_sign_q);
        if (s2_spec_q) begin
            out_d = s2_spec_val_q;
        end else if (ovf) begin
            out_d = to_inf ? {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}} : {s2_sign_q, MAX_MAG};
        end else begin
            // Mantissa carry leaves the fraction bits zero, so one slice serves both cases
            out_d = {s2_sign_q, hidden ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, mr[MAN_W-1:0]};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q <= '0;
        end else if (en3 && v2_q) begin
            out_q <= out_d;
        end
    end

    assign Data_Out  = out_q;
    assign Valid_Out = v3_q;

`ifdef FP_ADDER_FLAGS_EN
    logic       snan_a, snan_b, s1_inv_q, s2_inv_q;
    logic [3:0] flags_d, flags_q;

    assign snan_a = nan_a & ~fa[MAN_W-1];
    assign snan_b = nan_b & ~fb[MAN_W-1];

    always_comb begin
        flags_d               = '0;
        flags_d[FLAG_INVALID] = s2_inv_q;
        if (!s2_spec_q) begin
            flags_d[FLAG_OVERFLOW]  = ovf;
            flags_d[FLAG_INEXACT]   = inexact_r | ovf;
            flags_d[FLAG_UNDERFLOW] = ~s2_mant_q[MW-1] & inexact_r;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_inv_q <= 1'b0;
            s2_inv_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            if (accept)        s1_inv_q <= snan_a | snan_b | (inf_a & inf_b & eff_sub);
            if (en2 && v1_q)   s2_inv_q <= s1_inv_q;
            if (en3 && v2_q)   flags_q  <= flags_d;
        end
    end

    assign Flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe (FP32 plus an FP16 instance); builds with or without
// FP_ADDER_FLAGS_EN.
module tb_fp_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b, dout;
    logic        mode, vin, rin, vout, rout;
    logic [1:0]  rm;
    logic [3:0]  flags;

    logic [15:0] a16, b16, dout16;
    logic        vin16, rin16, vout16;
    logic [3:0]  flags16;

    int n_chk = 0;
    int n_bad = 0;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Data_A    (a),
        .Data_B    (b),
        .Mode      (mode),
        .RMode     (rm),
        .Valid_In  (vin),
        .Ready_In  (rin),
        .Data_Out  (dout),
        .Valid_Out (vout),
`ifdef FP_ADDER_FLAGS_EN
        .Flags     (flags),
`endif
        .Ready_Out (rout)
    );

    fp_adder_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Data_A    (a16),
        .Data_B    (b16),
        .Mode      (1'b0),
        .RMode     (2'b00),
        .Valid_In  (vin16),
        .Ready_In  (rin16),
        .Data_Out  (dout16),
        .Valid_Out (vout16),
`ifdef FP_ADDER_FLAGS_EN
        .Flags     (flags16),
`endif
        .Ready_Out (1'b1)
    );

`ifndef FP_ADDER_FLAGS_EN
    assign flags   = 4'b0000;
    assign flags16 = 4'b0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One isolated operation with Ready_Out high; lat counts cycles from accept to Valid_Out
    task automatic run_op(input logic [31:0] opa, input logic [31:0] opb, input logic md,
                          input logic [1:0] rmd, output logic [31:0] res,
                          output logic [3:0] flg, output int lat);
        @(posedge clk); #1;
        a = opa; b = opb; mode = md; rm = rmd; vin = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        lat = 99;
        res = 32'hDEAD_BEEF;
        flg = 4'hF;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (vout) begin
                lat = t;
                res = dout;
                flg = flags;
                break;
            end
        end
    endtask

    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          stale;
    logic [31:0] a_tab   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] exp_tab [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    initial begin
        rst_n = 1'b0; vin = 1'b0; rout = 1'b1; mode = 1'b0; rm = 2'b00;
        a = '0; b = '0; a16 = '0; b16 = '0; vin16 = 1'b0;

        #3;
        check_eq("rst_vout", vout, 1'b0);
        check_eq("rst_dout", dout, 32'h0);
        check_eq("rst_flags", flags, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_eq("rdy_after_rst", rin, 1'b1);

        // 1.0 + 2.0
        run_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, res, flg, lat);
        check_eq("add_1_2", res, 32'h40400000);
        check_eq("add_1_2_lat", lat, 3);
        check_eq("add_1_2_flags", flg, 4'b0000);

        // x - x zero sign
        run_op(32'h3F800000, 32'h3F800000, 1'b1, 2'b00, res, flg, lat);
        check_eq("sub_zero_rne", res, 32'h00000000);
        run_op(32'h3F800000, 32'h3F800000, 1'b1, 2'b01, res, flg, lat);
        check_eq("sub_zero_rdn", res, 32'h80000000);
        // (-0) + (-0)
        run_op(32'h80000000, 32'h80000000, 1'b0, 2'b00, res, flg, lat);
        check_eq("negzero_add", res, 32'h80000000);

        // max finite overflow
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, res, flg, lat);
        check_eq("ovf_rne", res, 32'h7F800000);
`ifdef FP_ADDER_FLAGS_EN
        check_eq("ovf_rne_flags", flg, 4'b0101);
`endif
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b11, res, flg, lat);
        check_eq("ovf_rtz", res, 32'h7F7FFFFF);
        run_op(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b01, res, flg, lat);
        check_eq("ovf_rdn_neg", res, 32'hFF800000);
        run_op(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, res, flg, lat);
        check_eq("ovf_rup_neg", res, 32'hFF7FFFFF);

        // inf - inf, denormals, inf + finite
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 2'b00, res, flg, lat);
        check_eq("inf_sub_inf", res, 32'hFFC00000);
`ifdef FP_ADDER_FLAGS_EN
        check_eq("inf_sub_inf_flags", flg, 4'b1000);
`endif
        run_op(32'h00000001, 32'h00000001, 1'b0, 2'b00, res, flg, lat);
        check_eq("denorm_add", res, 32'h00000002);
        check_eq("denorm_flags", flg, 4'b0000);
        run_op(32'h3F800000, 32'hFF800000, 1'b0, 2'b00, res, flg, lat);
        check_eq("fin_plus_ninf", res, 32'hFF800000);
        // 1.0 + 2^-24: exact tie, rounds to even
        run_op(32'h3F800000, 32'h33800000, 1'b0, 2'b00, res, flg, lat);
        check_eq("tie_even", res, 32'h3F800000);
        run_op(32'h3F800000, 32'h33800000, 1'b0, 2'b10, res, flg, lat);
        check_eq("tie_rup", res, 32'h3F800001);

        // stream of 8 with 5 stalled cycles at the start
        @(posedge clk); #1;
        fork
            begin
                logic rdy;
                int   tries;
                for (int i = 0; i < 8; i++) begin
                    a = a_tab[i]; b = 32'h3F800000; mode = 1'b0; rm = 2'b00; vin = 1'b1;
                    rdy = 1'b0;
                    tries = 0;
                    while (!rdy && tries < 50) begin
                        @(negedge clk);
                        rdy = rin;
                        if (i == 3 && tries == 0) check_eq("stall_rdy", rdy, 1'b0);
                        @(posedge clk); #1;
                        tries++;
                    end
                    check_eq("stream_accept", rdy, 1'b1);
                end
                vin = 1'b0;
            end
            begin
                logic got;
                rout = 1'b0;
                repeat (5) @(posedge clk);
                #1 rout = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    got = 1'b0;
                    res = 32'hDEAD_BEEF;
                    for (int t = 0; t < 60 && !got; t++) begin
                        @(negedge clk);
                        if (vout) begin
                            got = 1'b1;
                            res = dout;
                        end
                    end
                    check_eq("stream_res", res, exp_tab[j]);
                end
            end
        join
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (vout) stale++;
        end
        check_eq("stream_extra", stale, 0);

        // reset with 3 operations in flight
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40000000; mode = 1'b0; rm = 2'b00; vin = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        vin = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_vout", vout, 1'b0);
        check_eq("midrst_dout", dout, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_rdy", rin, 1'b1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (vout) stale++;
        end
        check_eq("midrst_stale", stale, 0);

        // FP16: 1.0 + 2.0
        @(posedge clk); #1;
        a16 = 16'h3C00; b16 = 16'h4000; vin16 = 1'b1;
        @(negedge clk);
        check_eq("fp16_rdy", rin16, 1'b1);
        @(posedge clk); #1;
        vin16 = 1'b0;
        lat = 99;
        res = 32'hDEAD_BEEF;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (vout16) begin
                lat = t;
                res = {16'h0, dout16};
                break;
            end
        end
        check_eq("fp16_add", res, 32'h00004200);
        check_eq("fp16_lat", lat, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
